// File: rtl/crypto_block_feeder_if.sv
// Bus bundle between the cipher job feeder and its surroundings:
// key load, plaintext byte stream, engine handshake, ciphertext output.
interface crypto_block_feeder_if #(
  parameter int CNT_W = 16
);
  logic [127:0]     key_in;
  logic             key_load;
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     plaintext;
  logic [127:0]     cipher_key;
  logic             encrypt_start;
  logic [127:0]     ciphertext;
  logic             encrypt_done;
  logic [127:0]     ct_out;
  logic             ct_valid;
  logic             ct_ready;
  logic [CNT_W-1:0] block_count;
  logic             timeout_err;
  logic             clear_err;

  // feeder side
  modport master (
    input  key_in, key_load, in_byte, in_valid, ciphertext, encrypt_done,
           ct_ready, clear_err,
    output in_ready, plaintext, cipher_key, encrypt_start, ct_out, ct_valid,
           block_count, timeout_err
  );

  // producer / engine / consumer side
  modport slave (
    output key_in, key_load, in_byte, in_valid, ciphertext, encrypt_done,
           ct_ready, clear_err,
    input  in_ready, plaintext, cipher_key, encrypt_start, ct_out, ct_valid,
           block_count, timeout_err
  );
endinterface

// File: rtl/crypto_block_feeder.sv
// Job controller for the 128-bit round cipher: latches a key, packs 16
// stream bytes into a block, kicks the engine, waits for done with a
// timeout and holds the ciphertext until the consumer takes it.
module crypto_block_feeder #(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 16
) (
  input logic             clk,
  input logic             rst,
  crypto_block_feeder_if.master bus
);

  typedef enum logic [1:0] {FILL, START, WAIT, HOLD} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic               key_valid;
  logic [3:0]         byte_cnt;
  logic [7:0]         timer;
  logic [15:0][7:0]   pt_q;      // lane 15 is the first byte, at [127:120]
  logic [127:0]       key_q;
  logic [127:0]       ct_q;
  logic [CNT_W-1:0]   blk_cnt_q;
  logic               err_q;

  logic in_ready, encrypt_start, ct_valid;
  logic byte_hs, ct_hs, tmo_hit, key_ok;

  assign byte_hs = bus.in_valid & in_ready;
  assign ct_hs   = ct_valid & bus.ct_ready;
  // done has priority over timeout in the same cycle
  assign tmo_hit = (state == WAIT) & ~bus.encrypt_done & (timer == TMO_LAST);
  // key is frozen while the engine owns it
  assign key_ok  = bus.key_load & ((state == FILL) | (state == HOLD));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:  if (byte_hs && byte_cnt == 4'd15) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT:  if (bus.encrypt_done) state_nxt = HOLD;
             else if (tmo_hit)     state_nxt = FILL;
      HOLD:  if (ct_hs) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    in_ready      = 1'b0;
    encrypt_start = 1'b0;
    ct_valid      = 1'b0;
    case (state)
      FILL:    in_ready      = key_valid;
      START:   encrypt_start = 1'b1;
      HOLD:    ct_valid      = 1'b1;
      default: ;
    endcase
  end

  // datapath: key, byte packing, timer, ciphertext capture, counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_q     <= '0;
      byte_cnt  <= '0;
      pt_q      <= '0;
      timer     <= '0;
      ct_q      <= '0;
      blk_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (key_ok) begin
        key_q     <= bus.key_in;
        key_valid <= 1'b1;
      end
      // byte_cnt wraps 15 -> 0 on the closing handshake
      if (byte_hs) begin
        byte_cnt <= byte_cnt + 4'd1;
        for (int i = 0; i < 16; i++)
          if (byte_cnt == 4'(i)) pt_q[15-i] <= bus.in_byte;
      end
      if (state == START)
        timer <= '0;
      else if (state == WAIT && !bus.encrypt_done)
        timer <= timer + 8'd1;
      if (state == WAIT && bus.encrypt_done)
        ct_q <= bus.ciphertext;
      if (ct_hs)
        blk_cnt_q <= blk_cnt_q + 1'b1;
      // a new timeout beats a simultaneous clear
      if (tmo_hit)            err_q <= 1'b1;
      else if (bus.clear_err) err_q <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.encrypt_start = encrypt_start;
  assign bus.ct_valid      = ct_valid;
  assign bus.plaintext     = pt_q;
  assign bus.cipher_key    = key_q;
  assign bus.ct_out        = ct_q;
  assign bus.block_count   = blk_cnt_q;
  assign bus.timeout_err   = err_q;

endmodule

// File: tb/tb_crypto_block_feeder.sv
// Directed bench for crypto_block_feeder with a queue scoreboard of
// expected plaintext blocks and ciphertexts.
module tb_crypto_block_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  crypto_block_feeder_if #(.CNT_W(16)) bus();

  crypto_block_feeder #(.TIMEOUT(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KEY2 = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] CT1  = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
  localparam logic [127:0] CT2  = 128'h0123456789ABCDEF_FEDCBA9876543210;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] blk(input logic [7:0] base);
    logic [127:0] e;
    e = '0;
    for (int i = 0; i < 16; i++) e[127-8*i -: 8] = base + 8'(i);
    return e;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},    bus.in_ready, 0);
    chk({tag, "_plaintext"},   bus.plaintext, 0);
    chk({tag, "_cipher_key"},  bus.cipher_key, 0);
    chk({tag, "_start"},       bus.encrypt_start, 0);
    chk({tag, "_ct_out"},      bus.ct_out, 0);
    chk({tag, "_ct_valid"},    bus.ct_valid, 0);
    chk({tag, "_block_count"}, bus.block_count, 0);
    chk({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  // streams 16 bytes back-to-back; returns at the negedge of the START cycle
  task automatic send_block(input logic [7:0] base);
    exp_q.push_back(blk(base));
    for (int i = 0; i < 16; i++) begin
      bus.in_byte  = base + 8'(i);
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (i < 15) chk("no_early_start", bus.encrypt_start, 0);
    end
    bus.in_valid = 1'b0;
    chk("start_pulse", bus.encrypt_start, 1);
    chk("start_in_ready", bus.in_ready, 0);
    chk("plaintext", bus.plaintext, exp_q.pop_front());
  endtask

  initial begin
    bus.key_in       = '0;
    bus.key_load     = 1'b0;
    bus.in_byte      = '0;
    bus.in_valid     = 1'b0;
    bus.ciphertext   = '0;
    bus.encrypt_done = 1'b0;
    bus.ct_ready     = 1'b0;
    bus.clear_err    = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);

    // no key yet: bytes are refused
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("nokey_in_ready", bus.in_ready, 0);
      chk("nokey_start", bus.encrypt_start, 0);
    end
    bus.in_valid = 1'b0;
    chk("nokey_plaintext", bus.plaintext, 0);

    // key load and first block
    bus.key_in   = KEY1;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
    chk("key1", bus.cipher_key, KEY1);
    chk("key_in_ready", bus.in_ready, 1);
    send_block(8'h10);
    @(negedge clk);
    chk("start_once", bus.encrypt_start, 0);
    chk("wait_in_ready", bus.in_ready, 0);

    // engine answers 9 cycles after start
    repeat (8) begin
      @(negedge clk);
      chk("wait_in_ready", bus.in_ready, 0);
      chk("wait_start", bus.encrypt_start, 0);
      chk("wait_ct_valid", bus.ct_valid, 0);
    end
    bus.encrypt_done = 1'b1;
    bus.ciphertext   = CT1;
    exp_q.push_back(CT1);
    @(negedge clk);
    bus.encrypt_done = 1'b0;
    bus.ciphertext   = ~CT1;
    chk("hold_ct_valid", bus.ct_valid, 1);
    chk("hold_ct_out", bus.ct_out, exp_q[0]);
    repeat (5) begin
      @(negedge clk);
      chk("stall_ct_valid", bus.ct_valid, 1);
      chk("stall_ct_out", bus.ct_out, exp_q[0]);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_count", bus.block_count, 0);
    end
    bus.ct_ready = 1'b1;
    @(negedge clk);
    bus.ct_ready = 1'b0;
    chk("taken_ct_out", bus.ct_out, exp_q.pop_front());
    chk("taken_ct_valid", bus.ct_valid, 0);
    chk("taken_count", bus.block_count, 1);
    chk("taken_in_ready", bus.in_ready, 1);

    // stray done while filling is ignored
    bus.encrypt_done = 1'b1;
    bus.ciphertext   = CT2;
    @(negedge clk);
    bus.encrypt_done = 1'b0;
    chk("stray_ct_valid", bus.ct_valid, 0);
    chk("stray_ct_out", bus.ct_out, CT1);
    chk("stray_in_ready", bus.in_ready, 1);

    // engine never answers; a key_load mid-run is ignored
    send_block(8'h20);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      bus.key_load = (k == 3);
      bus.key_in   = KEY2;
      chk("tmo_early_err", bus.timeout_err, 0);
      chk("tmo_in_ready", bus.in_ready, 0);
      chk("tmo_ct_valid", bus.ct_valid, 0);
    end
    @(negedge clk);
    bus.key_load = 1'b0;
    chk("tmo_err", bus.timeout_err, 1);
    chk("tmo_ct_valid_after", bus.ct_valid, 0);
    chk("tmo_back_fill", bus.in_ready, 1);
    chk("tmo_key_kept", bus.cipher_key, KEY1);
    chk("tmo_pt_kept", bus.plaintext, blk(8'h20));
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    chk("clear_err", bus.timeout_err, 0);

    // clear held across a new timeout: set wins
    send_block(8'h30);
    bus.clear_err = 1'b1;
    repeat (33) @(negedge clk);
    chk("set_beats_clear", bus.timeout_err, 1);
    @(negedge clk);
    bus.clear_err = 1'b0;
    chk("clear_again", bus.timeout_err, 0);

    // done in the timeout cycle: done wins
    send_block(8'h40);
    repeat (32) @(negedge clk);
    bus.encrypt_done = 1'b1;
    bus.ciphertext   = CT2;
    exp_q.push_back(CT2);
    @(negedge clk);
    bus.encrypt_done = 1'b0;
    chk("late_done_valid", bus.ct_valid, 1);
    chk("late_done_err", bus.timeout_err, 0);
    bus.ct_ready = 1'b1;
    @(negedge clk);
    bus.ct_ready = 1'b0;
    chk("late_done_ct", bus.ct_out, exp_q.pop_front());
    chk("late_done_count", bus.block_count, 2);

    // reset mid-WAIT
    send_block(8'h50);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.key_in   = KEY2;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
    chk("postrst_key", bus.cipher_key, KEY2);
    chk("postrst_ready", bus.in_ready, 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/crypto_block_feeder.md
Name: crypto_block_feeder

Overview:
Upstream job controller for the 128-bit round-cipher host. It latches a cipher key and assembles a 128-bit plaintext block from a byte stream. It then issues a single-cycle encrypt_start and waits for encrypt_done with a timeout. It captures the ciphertext and presents it on a valid/ready output until a downstream consumer takes it.

Parameters:
TIMEOUT, 32, cycles allowed in WAIT for encrypt_done (2..255); timer width 8 bits
CNT_W, 16, width of the completed-block counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
key_in  input  128  cipher key to latch
key_load  input  1  latch key_in this cycle (see Behaviour for when honoured)
in_byte  input  8  plaintext byte stream data
in_valid  input  1  in_byte valid
in_ready  output  1  feeder accepts in_byte this cycle
plaintext  output  128  assembled block to engine
cipher_key  output  128  latched key to engine
encrypt_start  output  1  one-cycle start pulse to engine
ciphertext  input  128  engine result
encrypt_done  input  1  engine completion pulse
ct_out  output  128  captured ciphertext
ct_valid  output  1  ct_out valid
ct_ready  input  1  downstream accepts ct_out
block_count  output  CNT_W  blocks delivered, wraps modulo 2^CNT_W
timeout_err  output  1  sticky flag: engine timed out
clear_err  input  1  clears timeout_err

Behaviour:
- Reset, async and active-high, forces state FILL, byte_cnt=0, key_valid=0, and timer=0. All outputs go to 0: plaintext, cipher_key, encrypt_start, ct_out, ct_valid, block_count, timeout_err, in_ready.
- States are FILL, START, WAIT and HOLD, plus an internal key_valid flag.
- key_load is honoured in FILL and HOLD only. It sets cipher_key=key_in and key_valid=1 on the next edge. It is ignored in START and WAIT, so cipher_key stays stable for the whole engine run.
- If key_load coincides with a byte handshake in FILL, both take effect.
- FILL:
  - in_ready = key_valid (combinational, no dependence on in_valid).
  - A handshake (in_valid & in_ready) writes in_byte into plaintext. The first byte lands in [127:120], byte k in [127-8k -: 8]. byte_cnt increments.
  - The handshake with byte_cnt==15 moves to START and resets byte_cnt to 0.
  - A partial block is retained indefinitely.
- START: encrypt_start=1 for exactly this one cycle and in_ready=0. Next state is WAIT with timer=0.
- WAIT:
  - encrypt_done=1 gives ct_out<=ciphertext and ct_valid<=1 on that edge. Next state is HOLD.
  - Otherwise the timer increments. When the timer equals TIMEOUT-1 and done is absent, timeout_err<=1 and the state returns to FILL. ct_valid stays 0 and the plaintext register is left as is.
  - If done and timeout occur in the same cycle, done wins.
- HOLD:
  - ct_valid=1 and ct_out stay stable until ct_valid & ct_ready.
  - On that edge: ct_valid<=0, block_count<=block_count+1, next state FILL.
  - in_ready=0 in HOLD.
- encrypt_done in any state other than WAIT is ignored.
- timeout_err is sticky. clear_err clears it. If clear_err and a new timeout fall in the same cycle, the set wins.
- Latency: encrypt_start is asserted in the cycle after the 16th byte handshake. ct_valid rises the cycle after encrypt_done.
- Throughput: one block in flight. No new bytes are accepted from START until the HOLD handshake.

Test Plan:
1. Reset, then key_load with key_in=128'h000102030405060708090A0B0C0D0E0F, then stream bytes 0x10..0x1F back-to-back. Required: plaintext=128'h101112131415161718191A1B1C1D1E1F; encrypt_start high exactly one cycle, in the cycle after byte 0x1F; in_ready=0 during START/WAIT.
2. Engine model pulses encrypt_done 9 cycles after start with ciphertext=128'hDEADBEEF_00000000_CAFEF00D_12345678, and ct_ready is held low for 5 cycles. Required: ct_out equals that value and stays stable with ct_valid=1 throughout; after the handshake block_count=1 and in_ready=1.
3. No key loaded after reset, in_valid=1 for 20 cycles. Required: in_ready=0, no encrypt_start, byte_cnt stays 0.
4. Full block sent and engine never asserts done (TIMEOUT=32). Required: timeout_err=1 at the edge 32 cycles after the start pulse, state FILL, ct_valid=0; a later clear_err pulse returns timeout_err to 0.
5. key_load with a new key during WAIT, plus a spurious encrypt_done while in FILL. Required: cipher_key unchanged and no ct_valid.
6. rst asserted mid-WAIT, then deasserted. Required: all outputs 0 immediately; in_ready=0 until a fresh key_load.
